// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Contents: NOP encoding, default sequential PC increment, fetch FSM state type.
// Imported by the interface, the PC register and the fetch unit top.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEFAULT = 32'd4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch unit and the imem/cache.
// Ports: imem_req/imem_addr (fetcher -> memory), imem_ack/imem_rdata (memory -> fetcher).
// Latency: ack may arrive in the same cycle req rises; rdata is valid only with ack.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register with load (redirect), increment and hold.
// Ports: clk/rst, load_i + load_addr_i, inc_i; pc_o current PC, pc_seq_o = pc + PC_INC.
// Latency: one cycle from control to pc_o; load has priority over increment.
module if_fetch_unit_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_addr_i,
  input  logic        inc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_seq_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0.
  assign pc_seq_o = pc_q + PC_INC;
  assign pc_o     = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_seq_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage producer for the IF/ID register: owns the PC and the imem fetch handshake.
// Ports: clk/rst, freeze, branch_taken/branch_addr, imem (master), PC_out, Instruction_out, fetch_stall.
// Latency: instruction is combinational from imem_rdata on the ack cycle; HOLD replays it while frozen.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_addr,
  if_fetch_unit_if.master          imem,
  output logic [31:0]              PC_out,
  output logic [31:0]              Instruction_out,
  output logic                     fetch_stall
);

  fetch_state_t state_q, state_d;
  logic [31:0]  hold_buf_q, hold_buf_d;
  logic [31:0]  stale_addr_q, stale_addr_d;
  logic [31:0]  pc;
  logic [31:0]  pc_seq;
  logic         pc_load;
  logic         pc_inc;
  logic         avail;

  if_fetch_unit_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (pc_load),
    .load_addr_i (branch_addr),
    .inc_i       (pc_inc),
    .pc_o        (pc),
    .pc_seq_o    (pc_seq)
  );

  // Outputs. In DISCARD the bus keeps presenting the abandoned address so an
  // unacked request is never withdrawn or altered.
  always_comb begin
    imem.imem_req   = (state_q != HOLD);
    imem.imem_addr  = (state_q == DISCARD) ? stale_addr_q : pc;
    avail           = ((state_q == FETCH) && imem.imem_ack) || (state_q == HOLD);
    Instruction_out = NOP_INSTR;
    if ((state_q == FETCH) && imem.imem_ack) begin
      Instruction_out = imem.imem_rdata;
    end else if (state_q == HOLD) begin
      Instruction_out = hold_buf_q;
    end
    // A redirect flushes IF/ID, so the pipeline must not freeze on it.
    fetch_stall = ~avail & ~branch_taken;
    PC_out      = pc_seq;
  end

  // Next state.
  always_comb begin
    state_d      = state_q;
    hold_buf_d   = hold_buf_q;
    stale_addr_d = stale_addr_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;

    if (branch_taken) begin
      pc_load = 1'b1;
      // An unacked request must run to completion; remember its address and
      // swallow its response. Re-branching in DISCARD keeps the same address.
      if ((state_q != HOLD) && !imem.imem_ack) begin
        stale_addr_d = imem.imem_addr;
        state_d      = DISCARD;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            if (freeze) begin
              hold_buf_d = imem.imem_rdata;
              state_d    = HOLD;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!freeze) begin
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
        end
        DISCARD: begin
          if (imem.imem_ack) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      hold_buf_q   <= NOP_INSTR;
      stale_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      hold_buf_q   <= hold_buf_d;
      stale_addr_q <= stale_addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed-vector bench for if_fetch_unit with a queue-based scoreboard.
// Driver applies one vector per cycle after posedge and pushes the expected outputs;
// monitor pops at negedge and compares the fields selected by each vector's mask.
module tb_if_fetch_unit;

  typedef struct {
    int          id;
    logic [4:0]  mask;   // {req, addr, pc_out, instr, stall}
    logic        req;
    logic [31:0] addr;
    logic [31:0] pcout;
    logic [31:0] instr;
    logic        stall;
  } exp_t;

  localparam logic [4:0] M_ALL  = 5'b11111;
  localparam logic [4:0] M_HOLD = 5'b10111;  // address is don't-care in HOLD
  localparam logic [4:0] M_NONE = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
  logic        fetch_stall;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (32'd4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem            (bus),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out),
    .fetch_stall     (fetch_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  task automatic vec(input logic r, input logic frz, input logic br, input logic [31:0] baddr,
                     input logic ack, input logic [31:0] rdata, input logic [4:0] mask,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pcout,
                     input logic [31:0] e_instr, input logic e_stall);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    freeze         = frz;
    branch_taken   = br;
    branch_addr    = baddr;
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
    e.id    = n_vec;
    e.mask  = mask;
    e.req   = e_req;
    e.addr  = e_addr;
    e.pcout = e_pcout;
    e.instr = e_instr;
    e.stall = e_stall;
    sb_q.push_back(e);
    n_vec++;
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.mask[4]) check(e.id, "imem_req",        {31'b0, bus.imem_req}, {31'b0, e.req});
        if (e.mask[3]) check(e.id, "imem_addr",       bus.imem_addr,          e.addr);
        if (e.mask[2]) check(e.id, "PC_out",          PC_out,                 e.pcout);
        if (e.mask[1]) check(e.id, "Instruction_out", Instruction_out,        e.instr);
        if (e.mask[0]) check(e.id, "fetch_stall",     {31'b0, fetch_stall},   {31'b0, e.stall});
      end
    end
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;

    //   rst frz br  baddr          ack rdata          mask    req addr           pc_out         instr          stall
    vec(1, 0, 0, 32'h0,          0, 32'h0,          M_NONE, 1, 32'h0,          32'h0,         32'h0,         1);
    // Reset state, no ack yet
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h0,          32'h4,         32'h0,         1);
    // Zero-wait memory, four back-to-back fetches
    vec(0, 0, 0, 32'h0,          1, 32'h11,         M_ALL,  1, 32'h0,          32'h4,         32'h11,        0);
    vec(0, 0, 0, 32'h0,          1, 32'h22,         M_ALL,  1, 32'h4,          32'h8,         32'h22,        0);
    vec(0, 0, 0, 32'h0,          1, 32'h33,         M_ALL,  1, 32'h8,          32'hC,         32'h33,        0);
    vec(0, 0, 0, 32'h0,          1, 32'h44,         M_ALL,  1, 32'hC,          32'h10,        32'h44,        0);
    // Two-cycle memory: stall 1,0,1,0 with stable address
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h10,         32'h14,        32'h0,         1);
    vec(0, 0, 0, 32'h0,          1, 32'h55,         M_ALL,  1, 32'h10,         32'h14,        32'h55,        0);
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h14,         32'h18,        32'h0,         1);
    vec(0, 0, 0, 32'h0,          1, 32'h66,         M_ALL,  1, 32'h14,         32'h18,        32'h66,        0);
    // Freeze on ack -> HOLD replays the word, no request
    vec(0, 1, 0, 32'h0,          1, 32'hE3A0_1005,  M_ALL,  1, 32'h18,         32'h1C,        32'hE3A0_1005, 0);
    vec(0, 1, 0, 32'h0,          0, 32'h0,          M_HOLD, 0, 32'h0,          32'h1C,        32'hE3A0_1005, 0);
    vec(0, 1, 0, 32'h0,          0, 32'h0,          M_HOLD, 0, 32'h0,          32'h1C,        32'hE3A0_1005, 0);
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_HOLD, 0, 32'h0,          32'h1C,        32'hE3A0_1005, 0);
    // Freeze released: pc advanced by 4, new request issued
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h1C,         32'h20,        32'h0,         1);
    // Branch while 0x1C is unacked -> DISCARD keeps 0x1C on the bus
    vec(0, 0, 1, 32'h100,        0, 32'h0,          M_ALL,  1, 32'h1C,         32'h20,        32'h0,         0);
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h1C,         32'h104,       32'h0,         1);
    vec(0, 0, 0, 32'h0,          1, 32'hDEAD_BEEF,  M_ALL,  1, 32'h1C,         32'h104,       32'h0,         1);
    vec(0, 0, 0, 32'h0,          1, 32'h77,         M_ALL,  1, 32'h100,        32'h104,       32'h77,        0);
    // Branch + freeze in HOLD: branch wins
    vec(0, 1, 0, 32'h0,          1, 32'h88,         M_ALL,  1, 32'h104,        32'h108,       32'h88,        0);
    vec(0, 1, 1, 32'h200,        0, 32'h0,          M_HOLD, 0, 32'h0,          32'h108,       32'h88,        0);
    vec(0, 0, 0, 32'h0,          1, 32'h99,         M_ALL,  1, 32'h200,        32'h204,       32'h99,        0);
    // Re-branch inside DISCARD: stale address unchanged
    vec(0, 0, 1, 32'h300,        0, 32'h0,          M_ALL,  1, 32'h204,        32'h208,       32'h0,         0);
    vec(0, 0, 1, 32'h400,        0, 32'h0,          M_ALL,  1, 32'h204,        32'h304,       32'h0,         0);
    vec(0, 0, 0, 32'h0,          1, 32'h0BAD_0BAD,  M_ALL,  1, 32'h204,        32'h404,       32'h0,         1);
    vec(0, 0, 0, 32'h0,          1, 32'hAA,         M_ALL,  1, 32'h400,        32'h404,       32'hAA,        0);
    // Branch on an acked cycle -> straight to FETCH at the top of memory, then wrap
    vec(0, 0, 1, 32'hFFFF_FFFC,  1, 32'hBB,         M_ALL,  1, 32'h404,        32'h408,       32'hBB,        0);
    vec(0, 0, 0, 32'h0,          1, 32'hCC,         M_ALL,  1, 32'hFFFF_FFFC,  32'h0,         32'hCC,        0);
    vec(0, 0, 0, 32'h0,          1, 32'hDD,         M_ALL,  1, 32'h0,          32'h4,         32'hDD,        0);
    // Reset while in DISCARD
    vec(0, 0, 1, 32'h500,        0, 32'h0,          M_ALL,  1, 32'h4,          32'h8,         32'h0,         0);
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h4,          32'h504,       32'h0,         1);
    vec(1, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h4,          32'h504,       32'h0,         1);
    vec(0, 0, 0, 32'h0,          0, 32'h0,          M_ALL,  1, 32'h0,          32'h4,         32'h0,         1);
    vec(0, 0, 0, 32'h0,          1, 32'hEE,         M_ALL,  1, 32'h0,          32'h4,         32'hEE,        0);

    // Let the monitor drain the last expectation.
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
